matmul_controller_nxn: RTL
==========================

Name: matmul_controller_nxn

Overview:
Parametrised successor to the 2x2 matmul controller. It buffers an NxN operand matrix A and an NxN operand matrix B loaded element-by-element, then feeds them into an external NxN output-stationary systolic array with diagonal skew. It captures the NxN accumulator results and presents them to the host one DW-bit lane at a time. It adds accumulate-across-runs mode, an explicit host release handshake, and lane-sliced readout of results wider than the data bus.

Parameters:
N, 2, matrix dimension (N>=2); array is NxN
DW, 8, operand and output-bus width (unsigned operands)
ACC_W, 18, accumulator width of each array result
IW, $clog2(N), row/column index width (derived)
LANES, (ACC_W+DW-1)/DW, DW-bit lanes per result (derived)
LW, max(1,$clog2(LANES)), lane-select width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
load_en  in  1  write in_data into operand buffer (accepted only in IDLE)
load_sel_ab  in  1  0=A, 1=B
load_row  in  IW  element row
load_col  in  IW  element column
in_data  in  DW  element value
acc_mode  in  1  1=do not clear array on release (results accumulate into next run)
clear_acc  in  1  pulse in IDLE: clear array accumulators
release  in  1  pulse in OUTPUT: host finished reading, return to IDLE
output_en  in  1  enable readout mux
output_sel  in  2*IW  result index row*N+col
lane_sel  in  LW  DW-bit lane of selected result (0 = LSBs)
a_feed  out  N*DW  row i operand on bits [i*DW +: DW]
b_feed  out  N*DW  column j operand on bits [j*DW +: DW]
clear  out  1  array accumulator clear
c_flat  in  N*N*ACC_W  array results, C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
out_data  out  DW  selected lane
busy  out  1  high in FEED or CAPTURE
done  out  1  high in OUTPUT

Behaviour:
- Reset (rst_n low at edge): state IDLE, all loaded flags 0, feed counter 0, captured C regs 0. Operand buffers are not reset. Outputs after reset: a_feed=b_feed=0, clear=0, out_data=0, busy=0, done=0.
- States: IDLE, FEED, CAPTURE, OUTPUT.
- IDLE:
  - load_en writes A/B[row][col] and sets that element's flag. Rewriting an element overwrites it.
  - Next cycle after all 2*N*N flags are set, go to FEED. The last load and the transition check happen in the same cycle, so FEED starts the cycle after the last load edge.
  - clear_acc=1 drives clear=1 combinationally in IDLE.
- FEED:
  - Lasts exactly 3N-2 cycles; counter t runs 0..3N-3, then go to CAPTURE.
  - Row i driven with A[i][t-i] when 0<=t-i<N, else 0.
  - Column j driven with B[t-j][j] when 0<=t-j<N, else 0.
  - For t>2N-2 all feeds are 0 (drain).
- CAPTURE: one cycle. Latches c_flat into C regs at its closing edge, then go to OUTPUT.
- OUTPUT:
  - done=1.
  - out_data = lane lane_sel of C[output_sel] when output_en=1, else 0.
  - Lane bits beyond ACC_W read as 0.
  - output_sel>=N*N or lane_sel>=LANES reads 0.
- OUTPUT exit: release=1 returns to IDLE at the next edge, clears all loaded flags and resets the counter. In that same cycle clear=!acc_mode. C regs hold their values until the next CAPTURE.
- Ignored inputs:
  - load_en outside IDLE: buffers and flags unchanged.
  - release outside OUTPUT.
  - clear_acc outside IDLE.
- clear is purely combinational: (IDLE & clear_acc) | (OUTPUT & release & !acc_mode).
- Reset mid-operation returns to IDLE at once; clear stays 0. The array's own reset clears its accumulators.
- Latency: from the edge that accepts the last load to done=1 is 3N cycles (N=2: 6).

Test Plan:
- Basic multiply, N=2, external array model: load A=[1,2;3,4], B=[5,6;7,8] in shuffled order -> busy for 5 cycles, done asserted 6 cycles after last load. Read lane0 of sel 0..3 -> 19,22,43,50; lane1 and lane2 -> 0.
- Feed skew, N=2: after the load above, capture a_feed/b_feed per FEED cycle -> t0 row0=1, row1=0, col0=5, col1=0; t1 row0=2, row1=3, col0=7, col1=6; t2 row0=0, row1=4, col0=0, col1=8; t3 all 0.
- Accumulate: run the basic test with acc_mode=1, release, then reload the same operands -> 38,44,86,100. clear never pulses until a clear_acc pulse in IDLE.
- Wide lanes: all A and B elements 255 -> C00=130050=0x1FC02. Lane0=0x02, lane1=0xFC, lane2=0x01. output_en=0 -> out_data=0.
- Ignored inputs: load_en with different data during FEED and OUTPUT -> results unchanged. release in IDLE -> no state change. Overwriting A[0][0] twice in IDLE -> last value used.
- Reset mid-FEED: rst_n low at t=1 -> state IDLE, flags 0, busy=0. A full reload then produces correct results.

Source files
------------

// File: rtl/matmul_controller_nxn.sv
// Operand buffer and feed sequencer for an external NxN output-stationary
// systolic array. Buffers A and B element-by-element, streams them with
// diagonal skew, captures the accumulator results and presents them one
// DW-bit lane at a time.
// The handshake input is named release_req because release is a reserved word.
module matmul_controller_nxn #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 18,
  parameter int IW    = $clog2(N),
  parameter int LANES = (ACC_W + DW - 1) / DW,
  parameter int LW    = ($clog2(LANES) > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic                   load_sel_ab,
  input  logic [IW-1:0]          load_row,
  input  logic [IW-1:0]          load_col,
  input  logic [DW-1:0]          in_data,
  input  logic                   acc_mode,
  input  logic                   clear_acc,
  input  logic                   release_req,
  input  logic                   output_en,
  input  logic [2*IW-1:0]        output_sel,
  input  logic [LW-1:0]          lane_sel,
  output logic [N*DW-1:0]        a_feed,
  output logic [N*DW-1:0]        b_feed,
  output logic                   clear,
  input  logic [N*N*ACC_W-1:0]   c_flat,
  output logic [DW-1:0]          out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] T_LAST = CW'(3 * N - 3);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_CAPTURE, S_OUTPUT} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          t_cnt;
  logic [DW-1:0]          a_buf [N][N];
  logic [DW-1:0]          b_buf [N][N];
  logic [N*N-1:0]         a_ld, b_ld;
  logic [N*N*ACC_W-1:0]   c_reg;
  logic                   load_ok;
  logic [ACC_W-1:0]       c_sel;
  logic [LANES*DW-1:0]    lanes_pad;

  assign load_ok = (state == S_IDLE) && load_en;

  // State register and skew counter; counter is zero outside FEED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      t_cnt <= '0;
    end else begin
      state <= state_nxt;
      t_cnt <= (state == S_FEED && t_cnt != T_LAST) ? t_cnt + 1'b1 : '0;
    end
  end

  // Per-element loaded flags, cleared when the host releases the results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_ld <= '0;
      b_ld <= '0;
    end else if (state == S_OUTPUT && release_req) begin
      a_ld <= '0;
      b_ld <= '0;
    end else if (load_ok) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          if (load_row == IW'(i) && load_col == IW'(j)) begin
            if (load_sel_ab) b_ld[i*N+j] <= 1'b1;
            else             a_ld[i*N+j] <= 1'b1;
          end
    end
  end

  // Operand buffers (not reset; validity is tracked by the flags)
  always_ff @(posedge clk) begin
    if (load_ok) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          if (load_row == IW'(i) && load_col == IW'(j)) begin
            if (load_sel_ab) b_buf[i][j] <= in_data;
            else             a_buf[i][j] <= in_data;
          end
    end
  end

  // Result capture at the closing edge of CAPTURE; held until the next run
  always_ff @(posedge clk) begin
    if (!rst_n)                  c_reg <= '0;
    else if (state == S_CAPTURE) c_reg <= c_flat;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (&a_ld && &b_ld) state_nxt = S_FEED;
      S_FEED:    if (t_cnt == T_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OUTPUT;
      S_OUTPUT:  if (release_req) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status, array clear and skewed operand feeds (row i lags by i, column j by j)
  always_comb begin
    busy   = (state == S_FEED) || (state == S_CAPTURE);
    done   = (state == S_OUTPUT);
    clear  = ((state == S_IDLE) && clear_acc) ||
             ((state == S_OUTPUT) && release_req && !acc_mode);
    a_feed = '0;
    b_feed = '0;
    if (state == S_FEED) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned k = 0; k < N; k++)
          if (32'(t_cnt) == i + k) begin
            a_feed[i*DW +: DW] = a_buf[i][k];
            b_feed[i*DW +: DW] = b_buf[k][i];
          end
    end
  end

  // Readout mux: result select, zero-pad to whole lanes, then lane select
  always_comb begin
    c_sel = '0;
    for (int unsigned s = 0; s < N * N; s++)
      if (32'(output_sel) == s) c_sel = c_reg[s*ACC_W +: ACC_W];
    lanes_pad = '0;
    lanes_pad[ACC_W-1:0] = c_sel;
    out_data = '0;
    if (state == S_OUTPUT && output_en) begin
      for (int unsigned l = 0; l < LANES; l++)
        if (32'(lane_sel) == l) out_data = lanes_pad[l*DW +: DW];
    end
  end

endmodule
